// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - self-checking test-vector engine: replays stored vectors into a DUT and counts masked mismatches
module vector_checker #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_en,
  input  logic [$clog2(DEPTH)-1:0]      ld_addr,
  input  logic [IN_W+2*OUT_W-1:0]       ld_data,
  input  logic [$clog2(DEPTH):0]        num_vec,
  input  logic                          start,
  output logic [IN_W-1:0]               dut_in,
  input  logic [OUT_W-1:0]              dut_out,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          err_pulse,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [CNT_W-1:0]              vec_cnt,
  output logic [$clog2(DEPTH)-1:0]      first_err_idx,
  output logic                          first_err_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = IN_W + 2*OUT_W;
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]      n_last_q, n_last_d;
  logic [IN_W-1:0]    dut_in_q, dut_in_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic [AW-1:0]      fe_idx_q, fe_idx_d;
  logic               fe_vld_q, fe_vld_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [DW-1:0]      mem_d [DEPTH];

  logic               pipe_vld_q  [LAT+1];
  logic               pipe_vld_d  [LAT+1];
  logic [OUT_W-1:0]   pipe_exp_q  [LAT+1];
  logic [OUT_W-1:0]   pipe_exp_d  [LAT+1];
  logic [OUT_W-1:0]   pipe_care_q [LAT+1];
  logic [OUT_W-1:0]   pipe_care_d [LAT+1];
  logic [AW-1:0]      pipe_idx_q  [LAT+1];
  logic [AW-1:0]      pipe_idx_d  [LAT+1];

  logic [DW-1:0]      rd_word;
  logic [AW:0]        n_clamp;
  logic               cmp_vld;
  logic               mism;
  logic               idle_like;

  assign rd_word   = mem_q[ptr_q];
  assign n_clamp   = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
  assign cmp_vld   = pipe_vld_q[LAT];
  // Case inequality so an X/Z on a cared output bit is reported as a mismatch.
  assign mism      = ((dut_out ^ pipe_exp_q[LAT]) & pipe_care_q[LAT]) !== '0;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    n_last_d    = n_last_q;
    dut_in_d    = dut_in_q;
    err_cnt_d   = err_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    err_pulse_d = 1'b0;
    fe_idx_d    = fe_idx_q;
    fe_vld_d    = fe_vld_q;
    mem_d       = mem_q;

    pipe_vld_d[0]  = (state_q == S_RUN);
    pipe_exp_d[0]  = rd_word[2*OUT_W-1 -: OUT_W];
    pipe_care_d[0] = rd_word[OUT_W-1:0];
    pipe_idx_d[0]  = ptr_q;
    for (int k = 1; k <= LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_exp_d[k]  = pipe_exp_q[k-1];
      pipe_care_d[k] = pipe_care_q[k-1];
      pipe_idx_d[k]  = pipe_idx_q[k-1];
    end

    if (cmp_vld) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (mism) begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!fe_vld_q) begin
          fe_idx_d = pipe_idx_q[LAT];
          fe_vld_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ld_en) mem_d[ld_addr] = ld_data;
        if (start) begin
          err_cnt_d   = '0;
          vec_cnt_d   = '0;
          fe_vld_d    = 1'b0;
          err_pulse_d = 1'b0;
          ptr_d       = '0;
          n_last_d    = n_clamp[AW-1:0] - AW'(1);
          state_d     = (n_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        dut_in_d = rd_word[DW-1 -: IN_W];
        ptr_d    = ptr_q + AW'(1);
        if (ptr_q == n_last_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cmp_vld && (pipe_idx_q[LAT] == n_last_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vector memory has no reset so a mid-run reset keeps the loaded vectors.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      n_last_q    <= '0;
      dut_in_q    <= '0;
      err_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      fe_idx_q    <= '0;
      fe_vld_q    <= 1'b0;
      for (int k = 0; k <= LAT; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_exp_q[k]  <= '0;
        pipe_care_q[k] <= '0;
        pipe_idx_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      n_last_q    <= n_last_d;
      dut_in_q    <= dut_in_d;
      err_cnt_q   <= err_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      err_pulse_q <= err_pulse_d;
      fe_idx_q    <= fe_idx_d;
      fe_vld_q    <= fe_vld_d;
      for (int k = 0; k <= LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_d[k];
        pipe_exp_q[k]  <= pipe_exp_d[k];
        pipe_care_q[k] <= pipe_care_d[k];
        pipe_idx_q[k]  <= pipe_idx_d[k];
      end
    end
  end

  assign dut_in        = dut_in_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = (state_q == S_DONE) && (err_cnt_q == '0);
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign vec_cnt       = vec_cnt_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_vld = fe_vld_q;

endmodule
